// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB encoder constants, PIDs and state encoding
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

  localparam int unsigned BIT_PERIOD = 4;
  localparam logic [1:0]  PHASE_LAST = 2'(BIT_PERIOD - 1);
  localparam logic [7:0]  SYNC_BYTE  = 8'h80;

  typedef enum logic [2:0] {
    ENC_IDLE,
    ENC_SYNC,
    ENC_PID,
    ENC_DATA,
    ENC_CRC,
    ENC_EOP_SE0,
    ENC_EOP_J,
    ENC_DONE
  } enc_state_t;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - bit-serial CRC16 engine, init may coincide with the first data bit
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst0_async,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] base;

  always_comb begin
    base  = init ? CRC16_INIT : crc_q;
    crc_d = base;
    if (en) begin
      crc_d = {base[14:0], 1'b0} ^ ((din ^ base[15]) ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst0_async) begin
    if (!rst0_async) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_encoder.sv
// rtl/usb_encoder.sv - USB packet serialiser: SYNC/PID/DATA/CRC, bit stuffing, NRZI, EOP
// Optional start guard on usb_interpack: USB_ENCODER_IPGUARD_EN
module usb_encoder
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst0_async,
  input  logic       speed,
  input  logic       usb_interpack,
  input  logic       enc_start,
  input  logic [3:0] enc_pid,
  input  logic       tfifo_empty,
  input  logic [7:0] tfifo_data,
  output logic       tfifo_rd,
  output logic       dtx_plus,
  output logic       dtx_minus,
  output logic       dtx_oe,
  output logic       enc_busy,
  output logic       enc_done
);

  enc_state_t  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  ones_q, ones_d;
  logic        stuffing_q, stuffing_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  pid_q, pid_d;
  logic        j_q, j_d;
  logic        se0_q, se0_d;
  logic        oe_q, oe_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic [3:0]  accept_pid;
  logic        crc_init, crc_en, crc_din;
  logic [15:0] crc_val;
  logic        emit, tx_bit, load_byte, stuff_due;

`ifdef USB_ENCODER_IPGUARD_EN
  logic       pend_q;
  logic [3:0] pend_pid_q;

  assign accept     = (state_q == ENC_IDLE) && (enc_start || pend_q) && usb_interpack;
  assign accept_pid = enc_start ? enc_pid : pend_pid_q;

  // Requests made while the bus is not yet quiet wait here, only while IDLE.
  always_ff @(posedge clk or negedge rst0_async) begin
    if (!rst0_async) begin
      pend_q     <= 1'b0;
      pend_pid_q <= '0;
    end else if (accept) begin
      pend_q     <= 1'b0;
    end else if ((state_q == ENC_IDLE) && enc_start) begin
      pend_q     <= 1'b1;
      pend_pid_q <= enc_pid;
    end
  end
`else
  logic unused_interpack;
  assign unused_interpack = usb_interpack;
  assign accept           = (state_q == ENC_IDLE) && enc_start;
  assign accept_pid       = enc_pid;
`endif

  assign stuff_due = !stuffing_q && (ones_q == 3'd6) &&
                     ((state_q == ENC_SYNC) || (state_q == ENC_PID) ||
                      (state_q == ENC_DATA) || (state_q == ENC_CRC));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    stuffing_d = stuffing_q;
    shift_d    = shift_q;
    pid_d      = pid_q;
    j_d        = j_q;
    se0_d      = se0_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rd_d       = 1'b0;
    done_d     = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_din    = 1'b0;
    emit       = 1'b0;
    tx_bit     = 1'b0;
    load_byte  = 1'b0;

    case (state_q)
      ENC_IDLE: begin
        phase_d = '0;
        j_d     = 1'b1;
        se0_d   = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        if (accept) begin
          state_d    = ENC_SYNC;
          pid_d      = accept_pid;
          bit_cnt_d  = '0;
          shift_d    = SYNC_BYTE;
          stuffing_d = 1'b0;
          oe_d       = 1'b1;
          busy_d     = 1'b1;
          emit       = 1'b1;
          tx_bit     = SYNC_BYTE[0];
        end
      end

      ENC_DONE: begin
        state_d = ENC_IDLE;
        phase_d = '0;
        j_d     = 1'b1;
        se0_d   = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == PHASE_LAST) begin
          if (stuff_due) begin
            // Inserted zero: shift register, counters and FIFO all hold.
            emit       = 1'b1;
            tx_bit     = 1'b0;
            stuffing_d = 1'b1;
          end else begin
            stuffing_d = 1'b0;
            case (state_q)
              ENC_SYNC: begin
                emit = 1'b1;
                if (bit_cnt_q == 4'd7) begin
                  state_d   = ENC_PID;
                  bit_cnt_d = '0;
                  shift_d   = {~pid_q, pid_q};
                  tx_bit    = pid_q[0];
                end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_bit    = shift_q[1];
                end
              end

              ENC_PID: begin
                if (bit_cnt_q == 4'd7) begin
                  if (is_data_pid(pid_q)) begin
                    crc_init  = 1'b1;
                    load_byte = 1'b1;
                  end else begin
                    state_d   = ENC_EOP_SE0;
                    bit_cnt_d = '0;
                    se0_d     = 1'b1;
                    ones_d    = '0;
                  end
                end else begin
                  emit      = 1'b1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_bit    = shift_q[1];
                end
              end

              ENC_DATA: begin
                if (bit_cnt_q == 4'd7) begin
                  load_byte = 1'b1;
                end else begin
                  emit      = 1'b1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_bit    = shift_q[1];
                  crc_en    = 1'b1;
                  crc_din   = shift_q[1];
                end
              end

              ENC_CRC: begin
                if (bit_cnt_q == 4'd15) begin
                  state_d   = ENC_EOP_SE0;
                  bit_cnt_d = '0;
                  se0_d     = 1'b1;
                  ones_d    = '0;
                end else begin
                  emit      = 1'b1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  tx_bit    = ~crc_val[4'd14 - bit_cnt_q];
                end
              end

              ENC_EOP_SE0: begin
                if (bit_cnt_q == 4'd1) begin
                  state_d = ENC_EOP_J;
                  j_d     = 1'b1;
                  se0_d   = 1'b0;
                end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                end
              end

              ENC_EOP_J: begin
                state_d = ENC_DONE;
                phase_d = '0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                j_d     = 1'b1;
              end

              default: ;
            endcase

            // Byte boundary: fetch the next payload byte or fall into CRC.
            if (load_byte) begin
              bit_cnt_d = '0;
              emit      = 1'b1;
              if (!tfifo_empty) begin
                state_d = ENC_DATA;
                shift_d = tfifo_data;
                rd_d    = 1'b1;
                tx_bit  = tfifo_data[0];
                crc_en  = 1'b1;
                crc_din = tfifo_data[0];
              end else begin
                state_d = ENC_CRC;
                tx_bit  = ~(crc_init ? CRC16_INIT[15] : crc_val[15]);
              end
            end
          end
        end
      end
    endcase

    // NRZI: zero toggles the line, one holds it.
    if (emit) begin
      j_d    = tx_bit ? j_q : ~j_q;
      se0_d  = 1'b0;
      ones_d = tx_bit ? (ones_q + 3'd1) : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst0_async) begin
    if (!rst0_async) begin
      state_q    <= ENC_IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      ones_q     <= '0;
      stuffing_q <= 1'b0;
      shift_q    <= '0;
      pid_q      <= '0;
      j_q        <= 1'b1;
      se0_q      <= 1'b0;
      oe_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      stuffing_q <= stuffing_d;
      shift_q    <= shift_d;
      pid_q      <= pid_d;
      j_q        <= j_d;
      se0_q      <= se0_d;
      oe_q       <= oe_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  usb_crc16 u_crc16 (
    .clk        (clk),
    .rst0_async (rst0_async),
    .init       (crc_init),
    .en         (crc_en),
    .din        (crc_din),
    .crc        (crc_val)
  );

  // J/K polarity follows speed so IDLE and reset always present J.
  assign dtx_plus  = ~se0_q & (j_q ~^ speed);
  assign dtx_minus = ~se0_q & ~(j_q ~^ speed);
  assign dtx_oe    = oe_q;
  assign tfifo_rd  = rd_q;
  assign enc_busy  = busy_q;
  assign enc_done  = done_q;

endmodule

// File: tb/tb_usb_encoder.sv
// tb/tb_usb_encoder.sv - scoreboard bench for usb_encoder
module tb_usb_encoder;
  import usb_pkg::*;

  logic       clk = 1'b0;
  logic       rst0_async = 1'b0;
  logic       speed = 1'b1;
  logic       usb_interpack = 1'b1;
  logic       enc_start = 1'b0;
  logic [3:0] enc_pid = 4'h0;
  logic       tfifo_empty = 1'b1;
  logic [7:0] tfifo_data = 8'h00;
  logic       tfifo_rd, dtx_plus, dtx_minus, dtx_oe, enc_busy, enc_done;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int oe_cycles = 0;
  logic aborted = 1'b0;
  logic prev_oe = 1'b0;
  logic prev_done = 1'b0;

  logic [1:0] exp_q[$];
  logic       raw_q[$];
  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  usb_encoder dut (
    .clk           (clk),
    .rst0_async    (rst0_async),
    .speed         (speed),
    .usb_interpack (usb_interpack),
    .enc_start     (enc_start),
    .enc_pid       (enc_pid),
    .tfifo_empty   (tfifo_empty),
    .tfifo_data    (tfifo_data),
    .tfifo_rd      (tfifo_rd),
    .dtx_plus      (dtx_plus),
    .dtx_minus     (dtx_minus),
    .dtx_oe        (dtx_oe),
    .enc_busy      (enc_busy),
    .enc_done      (enc_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] lvl(input logic j, input logic fs);
    return (j ~^ fs) ? 2'b10 : 2'b01;
  endfunction

  task automatic push_sym(input logic [1:0] s);
    repeat (4) exp_q.push_back(s);
  endtask

  task automatic add_bits(input logic [15:0] v, input int n, input bit msb_first);
    for (int i = 0; i < n; i++) raw_q.push_back(msb_first ? v[n-1-i] : v[i]);
  endtask

  // Line model: stuffing after six ones, NRZI from J, then SE0 SE0 J.
  task automatic build_line(input logic fs);
    logic j;
    int   ones;
    j = 1'b1;
    ones = 0;
    foreach (raw_q[i]) begin
      if (!raw_q[i]) j = ~j;
      push_sym(lvl(j, fs));
      ones = raw_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        j = ~j;
        push_sym(lvl(j, fs));
        ones = 0;
      end
    end
    push_sym(2'b00);
    push_sym(2'b00);
    push_sym(lvl(1'b1, fs));
    raw_q.delete();
  endtask

  task automatic start_pkt(input logic [3:0] pid);
    @(negedge clk);
    enc_pid   = pid;
    enc_start = 1'b1;
    @(negedge clk);
    enc_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (done_cnt > base), 1);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (tfifo_rd === 1'b1) begin
      rd_cnt++;
      check("rd_while_empty", tfifo_empty, 0);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    tfifo_empty = (fifo_q.size() == 0);
    tfifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (dtx_oe === 1'b1) begin
      oe_cycles++;
      if (exp_q.size() == 0) begin
        check("oe_unexpected", dtx_oe, 0);
      end else begin
        e = exp_q.pop_front();
        check("line_plus_minus_busy", {dtx_plus, dtx_minus, enc_busy}, {e, 1'b1});
      end
    end else if (prev_oe === 1'b1) begin
      if (aborted) begin
        check("done_after_reset", enc_done, 0);
        aborted = 1'b0;
      end else begin
        check("done_after_eop", enc_done, 1);
        check("bits_left_at_eop", exp_q.size(), 0);
      end
    end
    if (prev_done === 1'b1) check("done_width", enc_done, 0);
    if (enc_done === 1'b1) done_cnt++;
    prev_oe   = dtx_oe;
    prev_done = enc_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base_rd;
    int base_done;

    repeat (3) @(negedge clk);
    check("reset_oe", dtx_oe, 0);
    check("reset_busy", enc_busy, 0);
    rst0_async = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_oe", dtx_oe, 0);
    check("idle_rd", tfifo_rd, 0);
    check("idle_done", enc_done, 0);
    check("idle_fs_j", {dtx_plus, dtx_minus}, 2'b10);

    // FS ACK
    add_bits(16'h0080, 8, 0);
    add_bits(16'h00D2, 8, 0);
    build_line(1'b1);
    base_done = done_cnt;
    oe_cycles = 0;
    start_pkt(PID_ACK);
    wait_done(base_done, 200, "ack_done");
    check("ack_clks", oe_cycles, 76);

    // LS DATA1 zero-length
    speed = 1'b0;
    #1;
    check("idle_ls_j", {dtx_plus, dtx_minus}, 2'b01);
    add_bits(16'h0080, 8, 0);
    add_bits(16'h004B, 8, 0);
    add_bits(16'h0000, 16, 1);
    build_line(1'b0);
    base_done = done_cnt;
    base_rd   = rd_cnt;
    oe_cycles = 0;
    start_pkt(PID_DATA1);
    wait_done(base_done, 300, "zlp_done");
    check("zlp_clks", oe_cycles, 140);
    check("zlp_rd_count", rd_cnt - base_rd, 0);
    speed = 1'b1;

    // FS DATA0 payload 0xFF; sent CRC = ~0xFF00 = 0x00FF
    fifo_q.push_back(8'hFF);
    repeat (2) @(negedge clk);
    add_bits(16'h0080, 8, 0);
    add_bits(16'h00C3, 8, 0);
    add_bits(16'h00FF, 8, 0);
    add_bits(16'h00FF, 16, 1);
    build_line(1'b1);
    base_done = done_cnt;
    base_rd   = rd_cnt;
    oe_cycles = 0;
    start_pkt(PID_DATA0);
    wait_done(base_done, 400, "ff_done");
    check("ff_clks", oe_cycles, 180);
    check("ff_rd_count", rd_cnt - base_rd, 1);

    // Start while busy is ignored
    add_bits(16'h0080, 8, 0);
    add_bits(16'h005A, 8, 0);
    build_line(1'b1);
    base_done = done_cnt;
    start_pkt(PID_NAK);
    repeat (30) @(negedge clk);
    enc_pid   = PID_ACK;
    enc_start = 1'b1;
    @(negedge clk);
    enc_start = 1'b0;
    wait_done(base_done, 200, "nak_done");
    repeat (100) @(negedge clk);
    check("busy_start_packets", done_cnt - base_done, 1);

    // Start gating on usb_interpack
    add_bits(16'h0080, 8, 0);
    add_bits(16'h001E, 8, 0);
    build_line(1'b1);
    base_done = done_cnt;
    usb_interpack = 1'b0;
`ifdef USB_ENCODER_IPGUARD_EN
    start_pkt(PID_STALL);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("guard_hold_oe", dtx_oe, 0);
    end
    usb_interpack = 1'b1;
    @(negedge clk);
    check("guard_release_oe", dtx_oe, 1);
`else
    start_pkt(PID_STALL);
    check("noguard_start_oe", dtx_oe, 1);
    usb_interpack = 1'b1;
`endif
    wait_done(base_done, 200, "stall_done");

    // Reset in the middle of DATA
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    repeat (2) @(negedge clk);
    add_bits(16'h0080, 8, 0);
    add_bits(16'h004B, 8, 0);
    add_bits(16'h00A5, 8, 0);
    build_line(1'b1);
    base_done = done_cnt;
    base_rd   = rd_cnt;
    start_pkt(PID_DATA1);
    for (int i = 0; i < 200 && rd_cnt == base_rd; i++) @(negedge clk);
    check("mid_data_reached", rd_cnt - base_rd, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    aborted    = 1'b1;
    rst0_async = 1'b0;
    #1;
    check("async_reset_oe", dtx_oe, 0);
    check("async_reset_busy", enc_busy, 0);
    check("async_reset_rd", tfifo_rd, 0);
    check("async_reset_done", enc_done, 0);
    check("async_reset_j", {dtx_plus, dtx_minus}, 2'b10);
    repeat (2) @(negedge clk);
    exp_q.delete();
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst0_async = 1'b1;
    repeat (200) @(negedge clk);
    check("reset_no_done", done_cnt - base_done, 0);
    check("reset_idle_oe", dtx_oe, 0);
    check("reset_idle_busy", enc_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
